uart_pixel_assembler: RTL
=========================

// Module: uart_pixel_assembler
// PURPOSE
//  Assembles a stream of UART receiver bytes into multi-channel pixels and issues
//  one frame-buffer write per completed pixel. Sits between the UART RX core and
//  the frame-buffer BRAM write port. Adds channel/width parametrisation, selectable
//  byte order, inter-byte timeout resync, frame wrap and an explicit frame restart.
// PARAMETERS
//  CHANNELS      3       bytes per pixel (>=1)
//  DATA_W        8       bits per channel byte
//  ADDR_W        18      frame-buffer address width
//  FRAME_PIXELS  76800   pixels per frame (<= 2**ADDR_W); address wraps after last
//  TIMEOUT_CYC   100000  idle clk cycles mid-pixel before partial pixel is discarded (>=2)
//  MSB_FIRST     1       1: first byte -> pix MS channel; 0: first byte -> LS channel
// PORTS
//  clk          in   1                  system clock, all logic rising-edge
//  RST_BTN_n    in   1                  synchronous active-low reset
//  rx_ready     in   1                  1-cycle strobe, rx_data valid this cycle
//  rx_data      in   DATA_W             received byte
//  frame_start  in   1                  1-cycle strobe: drop partial pixel, address -> 0
//  adress       out  ADDR_W             write address, valid while wenable=1
//  pix          out  CHANNELS*DATA_W    assembled pixel, valid while wenable=1
//  wenable      out  1                  1-cycle write strobe
//  busy         out  1                  1 while a partial pixel is held (ch_cnt != 0)
//  frame_done   out  1                  1-cycle pulse, coincident with write of last pixel
//  timeout_err  out  1                  1-cycle pulse when a partial pixel is discarded
// BEHAVIOUR
//  - Reset (RST_BTN_n=0 at clk edge): all outputs 0, ch_cnt=0, timeout counter=0;
//    reset mid-pixel discards partial data, no write issued. Reset beats all inputs.
//  - States: COLLECT (ch_cnt 0..CHANNELS-1) and WRITE (single cycle). Byte strobes
//    are accepted in every state, including WRITE.
//  - rx_ready: byte stored in slot ch_cnt, ch_cnt++. On byte CHANNELS-1 (cycle t):
//    pix register loaded with full pixel, ch_cnt=0, WRITE entered; wenable=1 at t+1
//    with pix and adress stable; adress increments at t+2. Latency last byte->write = 1.
//  - Byte order: MSB_FIRST=1 -> byte k in pix[(CHANNELS-k)*DATA_W-1 -: DATA_W];
//    MSB_FIRST=0 -> byte k in pix[(k+1)*DATA_W-1 -: DATA_W].
//  - pix holds its value until the next completed pixel; slot registers are separate,
//    so a byte arriving in the WRITE cycle starts the next pixel without corrupting pix.
//  - Address: after each write, adress = (adress==FRAME_PIXELS-1) ? 0 : adress+1.
//    frame_done=1 in the same cycle as the wenable for address FRAME_PIXELS-1.
//  - Timeout: counter runs only while ch_cnt!=0 and rx_ready=0; cleared on any
//    rx_ready or when ch_cnt=0. Reaching TIMEOUT_CYC idle cycles: ch_cnt=0,
//    timeout_err=1 for 1 cycle, adress unchanged, no write.
//  - frame_start: ch_cnt=0, timeout counter cleared, adress=0 next cycle. If coincident
//    with wenable, that write completes at old address and adress still goes to 0.
//    If coincident with rx_ready, the byte is taken as channel 0 of the new frame.
//    If coincident with completion of the last byte, the pixel is written at adress 0.
//  - Priority per cycle: reset > frame_start > rx_ready > timeout.
//  - CHANNELS=1: every rx_ready produces a write next cycle; busy stays 0, no timeout.
// TESTING
//  1. Defaults; bytes 0x12,0x34,0x56 with gaps -> one wenable, pix=0x123456, adress=0; then adress=1.
//  2. MSB_FIRST=0; bytes 0x12,0x34,0x56 -> pix=0x563412 at adress 0.
//  3. TIMEOUT_CYC=16; bytes 0xAA,0xBB then 16 idle cycles -> timeout_err pulse, no write;
//     then 0x01,0x02,0x03 -> pix=0x010203 at adress 0.
//  4. FRAME_PIXELS=4; 5 pixels back-to-back (rx_ready every cycle) -> writes at 0,1,2,3,0;
//     frame_done with 4th write only; pix values never corrupted.
//  5. One byte 0x77, then frame_start, then 0x11,0x22,0x33 -> single write pix=0x112233 at adress 0.
//  6. RST_BTN_n=0 for 1 cycle after 2 bytes at adress 5 -> all outputs 0; next 3 bytes write at adress 0.

Source files
------------

// File: rtl/uart_pixel_assembler.sv
// Packs UART receiver bytes into CHANNELS-wide pixels and issues one frame-buffer
// write per completed pixel, with timeout resync, frame wrap and frame restart.
module uart_pixel_assembler #(
  parameter int CHANNELS     = 3,
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 18,
  parameter int FRAME_PIXELS = 76800,
  parameter int TIMEOUT_CYC  = 100000,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic                         clk,
  input  logic                         RST_BTN_n,
  input  logic                         rx_ready,
  input  logic [DATA_W-1:0]            rx_data,
  input  logic                         frame_start,
  output logic [ADDR_W-1:0]            adress,
  output logic [CHANNELS*DATA_W-1:0]   pix,
  output logic                         wenable,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         timeout_err
);

  localparam int CNT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  LAST_CH   = CNT_W'(CHANNELS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic {S_COLLECT, S_WRITE} state_t;

  state_t                       r_state;
  state_t                       w_state_next;
  logic [CNT_W-1:0]             r_ch_cnt;
  logic [DATA_W-1:0]            r_slot [CHANNELS];
  logic [CHANNELS*DATA_W-1:0]   r_pix;
  logic [ADDR_W-1:0]            r_adress;
  logic [TMO_W-1:0]             r_tmo_cnt;
  logic                         r_timeout_err;

  logic [CNT_W-1:0]             w_idx;
  logic                         w_complete;
  logic                         w_tmo_fire;
  logic [CHANNELS*DATA_W-1:0]   w_pix_next;

  // frame_start restarts the pixel, so a coincident byte lands in channel 0.
  always_comb begin
    w_idx      = frame_start ? '0 : r_ch_cnt;
    w_complete = rx_ready && (w_idx == LAST_CH);
    w_tmo_fire = !frame_start && !rx_ready && (r_ch_cnt != '0) && (r_tmo_cnt == TMO_LAST);
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_pix_next = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (MSB_FIRST)
        w_pix_next[(CHANNELS-k)*DATA_W-1 -: DATA_W] = (k == CHANNELS-1) ? rx_data : r_slot[k];
      else
        w_pix_next[(k+1)*DATA_W-1 -: DATA_W]        = (k == CHANNELS-1) ? rx_data : r_slot[k];
    end
  end

  // NOTE: slot storage has no reset; each slot is rewritten before the pixel that reads it completes.
  always_ff @(posedge clk) begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (rx_ready && (w_idx == CNT_W'(k)))
        r_slot[k] <= rx_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!RST_BTN_n) begin
      r_state       <= S_COLLECT;
      r_ch_cnt      <= '0;
      r_pix         <= '0;
      r_adress      <= '0;
      r_tmo_cnt     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_timeout_err <= w_tmo_fire;

      // A write in progress still lands at the old address; restart overrides the increment.
      if (frame_start)
        r_adress <= '0;
      else if (r_state == S_WRITE)
        r_adress <= (r_adress == LAST_ADDR) ? '0 : r_adress + ADDR_W'(1);

      if (rx_ready) begin
        if (w_complete) begin
          r_pix    <= w_pix_next;
          r_ch_cnt <= '0;
        end else begin
          r_ch_cnt <= w_idx + CNT_W'(1);
        end
      end else if (frame_start || w_tmo_fire) begin
        r_ch_cnt <= '0;
      end

      if (frame_start || rx_ready || (r_ch_cnt == '0) || w_tmo_fire)
        r_tmo_cnt <= '0;
      else
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  always_comb begin
    w_state_next = w_complete ? S_WRITE : S_COLLECT;
  end

  always_comb begin
    wenable     = (r_state == S_WRITE);
    frame_done  = (r_state == S_WRITE) && (r_adress == LAST_ADDR);
    busy        = (r_ch_cnt != '0);
    timeout_err = r_timeout_err;
    adress      = r_adress;
    pix         = r_pix;
  end

endmodule
